// File: rtl/cp0_unit_if.sv
// cp0_unit_if
// Bundles the coprocessor-0 signals exchanged between the pipeline M stage
// and the CP0 block.
//   A1, A2, DIn, WE     : mfc0 read address, mtc0 write address/data/enable
//   M_PC, M_bd          : PC and delay-slot flag of the instruction in M
//   M_excCode           : exception code carried into M (31 = none)
//   HWInt               : external hardware interrupt lines
//   EXLClr              : eret in M, clears SR.EXL
//   IntReq, EPC, DOut   : redirect request, eret target, mfc0 read data
// The master modport is the pipeline side; the slave modport is the CP0 side.
interface cp0_unit_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] M_PC;
    logic        M_bd;
    logic [4:0]  M_excCode;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;

    modport master (
        output A1, A2, DIn, WE, M_PC, M_bd, M_excCode, HWInt, EXLClr,
        input  IntReq, EPC, DOut
    );

    modport slave (
        input  A1, A2, DIn, WE, M_PC, M_bd, M_excCode, HWInt, EXLClr,
        output IntReq, EPC, DOut
    );
endinterface

// File: rtl/cp0_unit.sv
// cp0_unit
// Coprocessor 0: status (12), cause (13), EPC (14) and PRId (15) registers,
// interrupt/exception detection for the M stage, and mfc0/mtc0 access.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   reset  : synchronous, active-high; clears SR, Cause and EPC
//   bus    : cp0_unit_if.slave carrying the read/write port, M-stage
//            exception information, interrupt lines and the outputs
//            IntReq (combinational), EPC and DOut (combinational)
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h0000_2021
) (
    input  logic         clk,
    input  logic         reset,
    cp0_unit_if.slave    bus
);

    // SR fields
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    // Cause fields
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    // EPC
    logic [31:0] epc;

    logic        int_ok;
    logic        exc_ok;
    logic        int_req;
    logic [31:0] exc_pc;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    // Interrupts need an enabled, unmasked line; exceptions only need a real
    // code. Both are blocked while EXL is set, which is what makes nested
    // exceptions impossible and keeps eret and a new exception apart.
    always_comb begin
        int_ok  = (|(bus.HWInt & im)) & ie & ~exl;
        exc_ok  = (bus.M_excCode != 5'd31) & ~exl;
        int_req = int_ok | exc_ok;
        // A delay-slot instruction restarts at its branch, one word earlier.
        exc_pc  = bus.M_bd ? (bus.M_PC - 32'd4) : bus.M_PC;
    end

    // Register layout as seen by mfc0; unlisted bits read as zero.
    always_comb begin
        sr_word    = {16'd0, im, 8'd0, exl, ie};
        cause_word = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
    end

    // State update. IP samples the lines every cycle regardless of anything
    // else. Taking an exception/interrupt overrides any mtc0 in the same
    // cycle; otherwise mtc0 writes SR or EPC, and eret clears EXL (also when
    // combined with an SR write, in which case IM/IE still take the data).
    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            ip <= bus.HWInt;
            if (int_req) begin
                exl      <= 1'b1;
                exc_code <= int_ok ? 5'd0 : bus.M_excCode;
                bd       <= bus.M_bd;
                epc      <= {exc_pc[31:2], 2'b00};
            end else begin
                if (bus.WE && (bus.A2 == 5'd12)) begin
                    im  <= bus.DIn[15:10];
                    ie  <= bus.DIn[0];
                    exl <= bus.EXLClr ? 1'b0 : bus.DIn[1];
                end else if (bus.EXLClr) begin
                    exl <= 1'b0;
                end
                if (bus.WE && (bus.A2 == 5'd14)) begin
                    epc <= {bus.DIn[31:2], 2'b00};
                end
            end
        end
    end

    // Outputs. Reads show the current register contents, never the value
    // being written this cycle.
    always_comb begin
        bus.IntReq = int_req;
        bus.EPC    = epc;
        case (bus.A1)
            5'd12:   bus.DOut = sr_word;
            5'd13:   bus.DOut = cause_word;
            5'd14:   bus.DOut = epc;
            5'd15:   bus.DOut = PRID;
            default: bus.DOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit
// Directed test of cp0_unit: reset state, PRId and unimplemented reads,
// mtc0 to SR/EPC/Cause/PRId, interrupt and exception entry, interrupt
// priority, delay-slot EPC (including wrap at address 0), mtc0 discarded by
// a simultaneous exception, eret clearing EXL, and reset overriding all.
module tb_cp0_unit;

    logic clk;
    logic reset;
    int   assertCount;
    int   failCount;

    cp0_unit_if bus ();

    cp0_unit #(.PRID(32'h0000_2021)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive every pipeline-side input at once, then let it settle.
    task automatic applyStimulus(input logic we, input logic [4:0] a2,
                                 input logic [31:0] din, input logic [31:0] pc,
                                 input logic mbd, input logic [4:0] exc,
                                 input logic [5:0] hw, input logic clr);
        bus.WE        = we;
        bus.A2        = a2;
        bus.DIn       = din;
        bus.M_PC      = pc;
        bus.M_bd      = mbd;
        bus.M_excCode = exc;
        bus.HWInt     = hw;
        bus.EXLClr    = clr;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd31, 6'd0, 1'b0);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkReg(input string tag, input logic [4:0] addr,
                            input logic [31:0] expected);
        bus.A1 = addr;
        #1;
        checkOutput(tag, bus.DOut, expected);
    endtask

    task automatic mtc0(input logic [4:0] a2, input logic [31:0] din);
        applyStimulus(1'b1, a2, din, 32'd0, 1'b0, 5'd31, 6'd0, 1'b0);
        tick();
        idle();
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        bus.A1      = 5'd0;
        reset       = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        idle();

        // Reset state
        checkReg("reset_sr", 5'd12, 32'h0000_0000);
        checkReg("reset_cause", 5'd13, 32'h0000_0000);
        checkReg("reset_epc", 5'd14, 32'h0000_0000);
        checkOutput("reset_intreq", {31'd0, bus.IntReq}, 32'd0);

        // PRId and unimplemented address
        checkReg("prid", 5'd15, 32'h0000_2021);
        checkReg("unimpl_7", 5'd7, 32'h0000_0000);

        // Enable IM[0] and IE
        mtc0(5'd12, 32'h0000_0401);
        checkReg("sr_write", 5'd12, 32'h0000_0401);
        checkOutput("no_int_idle", {31'd0, bus.IntReq}, 32'd0);

        // Hardware interrupt on line 0
        applyStimulus(1'b0, 5'd0, 32'd0, 32'h0000_1000, 1'b0, 5'd31, 6'b000001, 1'b0);
        checkOutput("int_same_cycle", {31'd0, bus.IntReq}, 32'd1);
        tick();
        checkOutput("int_drops_exl", {31'd0, bus.IntReq}, 32'd0);
        checkReg("int_cause", 5'd13, 32'h0000_0400);
        checkReg("int_sr", 5'd12, 32'h0000_0403);
        checkOutput("int_epc", bus.EPC, 32'h0000_1000);

        // EXL blocks a pending interrupt and an exception; eret reopens
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd10, 6'b000001, 1'b0);
        checkOutput("exl_blocks", {31'd0, bus.IntReq}, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd10, 6'b000001, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd31, 6'b000001, 1'b0);
        checkOutput("eret_reopens", {31'd0, bus.IntReq}, 32'd1);
        checkReg("eret_sr", 5'd12, 32'h0000_0401);
        idle();

        // Interrupt beats exception code 4
        applyStimulus(1'b0, 5'd0, 32'd0, 32'h0000_2000, 1'b0, 5'd4, 6'b000001, 1'b0);
        checkOutput("prio_intreq", {31'd0, bus.IntReq}, 32'd1);
        tick();
        idle();
        checkReg("prio_cause", 5'd13, 32'h0000_0400);
        checkReg("prio_epc", 5'd14, 32'h0000_2000);

        // eret together with SR write: EXL cleared, IM/IE from data
        applyStimulus(1'b1, 5'd12, 32'h0000_0003, 32'd0, 1'b0, 5'd31, 6'd0, 1'b1);
        tick();
        idle();
        checkReg("eret_mtc0_sr", 5'd12, 32'h0000_0001);

        // Masked interrupt line does not request
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd31, 6'b000010, 1'b0);
        checkOutput("masked_int", {31'd0, bus.IntReq}, 32'd0);

        // Overflow in a delay slot
        applyStimulus(1'b0, 5'd0, 32'd0, 32'h0000_3010, 1'b1, 5'd12, 6'd0, 1'b0);
        checkOutput("ov_intreq", {31'd0, bus.IntReq}, 32'd1);
        tick();
        idle();
        checkReg("ov_epc", 5'd14, 32'h0000_300C);
        checkReg("ov_cause", 5'd13, 32'h8000_0030);
        checkReg("ov_sr", 5'd12, 32'h0000_0003);
        mtc0(5'd12, 32'h0000_0401);

        // Exception discards a simultaneous mtc0 to EPC
        applyStimulus(1'b1, 5'd14, 32'h1234_5678, 32'h0000_4004, 1'b0, 5'd8, 6'd0, 1'b0);
        checkOutput("race_intreq", {31'd0, bus.IntReq}, 32'd1);
        tick();
        idle();
        checkOutput("race_epc", bus.EPC, 32'h0000_4004);
        checkReg("race_cause", 5'd13, 32'h0000_0020);
        checkReg("race_sr", 5'd12, 32'h0000_0403);

        // Plain mtc0 to EPC aligns the address
        mtc0(5'd12, 32'h0000_0401);
        mtc0(5'd14, 32'h1234_5677);
        checkOutput("epc_write", bus.EPC, 32'h1234_5674);

        // Cause and PRId are read-only to mtc0
        mtc0(5'd13, 32'hFFFF_FFFF);
        checkReg("cause_ro", 5'd13, 32'h0000_0020);
        mtc0(5'd15, 32'hFFFF_FFFF);
        checkReg("prid_ro", 5'd15, 32'h0000_2021);

        // Delay-slot exception at PC 0 wraps
        applyStimulus(1'b0, 5'd0, 32'd0, 32'h0000_0000, 1'b1, 5'd12, 6'd0, 1'b0);
        tick();
        idle();
        checkOutput("wrap_epc", bus.EPC, 32'hFFFF_FFFC);
        checkReg("wrap_cause", 5'd13, 32'h8000_0030);

        // Read shows pre-edge value; IP follows lines even with EXL set
        applyStimulus(1'b1, 5'd14, 32'h0000_0100, 32'd0, 1'b0, 5'd31, 6'b101010, 1'b0);
        checkReg("no_bypass", 5'd14, 32'hFFFF_FFFC);
        tick();
        idle();
        checkReg("epc_after", 5'd14, 32'h0000_0100);
        checkReg("ip_track", 5'd13, 32'h8000_A830);

        // Reset overrides mtc0, exception and eret
        reset = 1'b1;
        applyStimulus(1'b1, 5'd12, 32'h0000_0401, 32'h0000_5000, 1'b0, 5'd4, 6'b000001, 1'b1);
        tick();
        reset = 1'b0;
        idle();
        checkReg("rst2_sr", 5'd12, 32'h0000_0000);
        checkReg("rst2_cause", 5'd13, 32'h0000_0000);
        checkReg("rst2_epc", 5'd14, 32'h0000_0000);
        checkOutput("rst2_intreq", {31'd0, bus.IntReq}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
